// File: rtl/riscv_fetch_pkg.sv
// Shared types for the fetch-stage sequencer: FSM states, redirect sources
// and the reset vector the PC register must agree with.
package riscv_fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    typedef enum logic [1:0] {
        NONE,
        TRAP,
        BR,
        JMP
    } redir_src_t;

endpackage

// File: rtl/riscv_fetch_ctrl_if.sv
// Instruction-memory request/response port plus the decode-side valid/ready
// handshake; master is the fetch sequencer, slave is memory + decode.
interface riscv_fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );

endinterface

// File: rtl/riscv_redirect_arb.sv
// Fixed-priority redirect select (trap > branch > jump); targets are
// word-aligned and the target reads zero when nothing redirects.
module riscv_redirect_arb
    import riscv_fetch_pkg::*;
(
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_pc,
    output logic        redir_any,
    output logic [31:0] pc_target,
    output redir_src_t  redir_src
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        redir_src = NONE;
        pc_target = 32'h0;
        if (trap_valid) begin
            redir_src = TRAP;
            pc_target = {trap_pc[31:2], 2'b00};
        end else if (br_valid) begin
            redir_src = BR;
            pc_target = {br_pc[31:2], 2'b00};
        end else if (jmp_valid) begin
            redir_src = JMP;
            pc_target = {jmp_pc[31:2], 2'b00};
        end
    end

    assign redir_any = trap_valid | br_valid | jmp_valid;

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// Fetch sequencer: steers the PC register, issues one imem request at a time,
// buffers one instruction for decode and drops responses made stale by redirects.
module riscv_fetch_ctrl
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [31:0]               pc_cur,
    output logic                      pc_stall,
    output logic                      pc_src_sel,
    output logic [31:0]               pc_target,
    input  logic                      redir_trap_valid,
    input  logic [31:0]               redir_trap_pc,
    input  logic                      redir_br_valid,
    input  logic [31:0]               redir_br_pc,
    input  logic                      redir_jmp_valid,
    input  logic [31:0]               redir_jmp_pc,
    riscv_fetch_ctrl_if.master        bus
);

    fetch_state_t state_q, state_d;
    logic         kill_q, kill_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         redir_any;
    logic         redirect;
    redir_src_t   redir_src;
    logic         imem_req;

    riscv_redirect_arb u_arb (
        .trap_valid (redir_trap_valid),
        .trap_pc    (redir_trap_pc),
        .br_valid   (redir_br_valid),
        .br_pc      (redir_br_pc),
        .jmp_valid  (redir_jmp_valid),
        .jmp_pc     (redir_jmp_pc),
        .redir_any  (redir_any),
        .pc_target  (pc_target),
        .redir_src  (redir_src)
    );

    assign redirect = (redir_src != NONE);

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        req_pc_d   = req_pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        imem_req   = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // A redirect owns the PC this cycle, so no request goes out at the old PC.
                imem_req = !redirect;
                if (imem_req && bus.imem_gnt) begin
                    req_pc_d = pc_cur;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect) begin
                        state_d = REQ;
                    end else begin
                        if_instr_d = bus.imem_rdata;
                        if_pc_d    = req_pc_q;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: if (bus.if_ready || redirect) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            kill_q     <= 1'b0;
            req_pc_q   <= 32'h0;
            if_instr_q <= 32'h0;
            if_pc_q    <= RESET_VECTOR;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q    <= state_d;
            kill_q     <= kill_d;
            req_pc_q   <= req_pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = pc_cur;
    assign bus.if_valid  = (state_q == HOLD);
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign pc_src_sel    = redir_any;
    assign pc_stall      = !(redir_any || (imem_req && bus.imem_gnt));

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Directed test-plan steps followed by a randomized run, checked against a
// transaction-level model of the fetch sequencer, PC register and memory.
module tb_riscv_fetch_ctrl;
    import riscv_fetch_pkg::*;

    localparam logic [31:0] RV = RESET_VECTOR_DEFAULT;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_cur;
    logic        pc_stall, pc_src_sel;
    logic [31:0] pc_target;
    logic        tv, bv, jv;
    logic [31:0] tpc, bpc, jpc;

    riscv_fetch_ctrl_if bus();

    riscv_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc_cur           (pc_cur),
        .pc_stall         (pc_stall),
        .pc_src_sel       (pc_src_sel),
        .pc_target        (pc_target),
        .redir_trap_valid (tv),
        .redir_trap_pc    (tpc),
        .redir_br_valid   (bv),
        .redir_br_pc      (bpc),
        .redir_jmp_valid  (jv),
        .redir_jmp_pc     (jpc),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: started (left IDLE), outstanding request, stale flag, held instruction.
    bit          m_started, m_out, m_stale, m_held;
    logic [31:0] m_out_pc, m_if_pc, m_if_instr;

    // Memory: one pending response with a programmable latency.
    bit          mem_pend;
    int          mem_cnt, mem_lat;
    logic [31:0] mem_addr_q;
    bit          scoreboard_on;

    // Outputs observed in the most recent cycle.
    logic        o_req, o_stall, o_sel, o_valid;
    logic [31:0] o_addr, o_tgt, o_instr, o_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_started  = 1'b0;
        m_out      = 1'b0;
        m_stale    = 1'b0;
        m_held     = 1'b0;
        m_out_pc   = 32'h0;
        m_if_pc    = RV;
        m_if_instr = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        e_any, e_req, e_stall;
        logic [31:0] e_tgt, s_pc, s_rdata;
        logic        s_rst, s_gnt, s_rvalid, s_ready;
        @(negedge clk);
        if (!reset_n) model_reset();
        e_any = tv | bv | jv;
        if (tv)      e_tgt = tpc & 32'hFFFF_FFFC;
        else if (bv) e_tgt = bpc & 32'hFFFF_FFFC;
        else if (jv) e_tgt = jpc & 32'hFFFF_FFFC;
        else         e_tgt = 32'h0;
        e_req   = m_started && !m_out && !m_held && !e_any;
        e_stall = !(e_any || (e_req && bus.imem_gnt));

        o_req = bus.imem_req;  o_addr = bus.imem_addr; o_stall = pc_stall;
        o_sel = pc_src_sel;    o_tgt = pc_target;      o_valid = bus.if_valid;
        o_instr = bus.if_instr; o_pc = bus.if_pc;

        check("pc_target", o_tgt, e_tgt);
        check("pc_src_sel", o_sel, e_any);
        check("imem_req", o_req, e_req);
        check("pc_stall", o_stall, e_stall);
        if (e_req) check("imem_addr", o_addr, pc_cur);
        check("if_valid", o_valid, m_held);
        check("if_pc", o_pc, m_if_pc);
        check("if_instr", o_instr, m_if_instr);
        if (scoreboard_on && m_held && bus.if_ready)
            check("delivered", o_instr, mem_word(o_pc));

        s_rst = reset_n; s_gnt = bus.imem_gnt; s_rvalid = bus.imem_rvalid;
        s_rdata = bus.imem_rdata; s_ready = bus.if_ready; s_pc = pc_cur;

        @(posedge clk);
        #1;
        if (!s_rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_held) begin
            if (s_ready || e_any) m_held = 1'b0;
        end else if (m_out) begin
            if (s_rvalid) begin
                if (!(m_stale || e_any)) begin
                    m_held     = 1'b1;
                    m_if_instr = s_rdata;
                    m_if_pc    = m_out_pc;
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (e_any) begin
                m_stale = 1'b1;
            end
        end else if (e_req && s_gnt) begin
            m_out    = 1'b1;
            m_out_pc = s_pc;
        end

        if (!s_rst)        pc_cur = RV;
        else if (!o_stall) pc_cur = o_sel ? o_tgt : pc_cur + 32'd4;

        bus.imem_rvalid = 1'b0;
        if (o_req && s_gnt) begin
            mem_pend   = 1'b1;
            mem_cnt    = mem_lat;
            mem_addr_q = s_pc;
        end
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(mem_addr_q);
                mem_pend        = 1'b0;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;  pc_cur = RV;
        tv = 1'b0; bv = 1'b0; jv = 1'b0;
        tpc = 32'h0; bpc = 32'h0; jpc = 32'h0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.if_ready = 1'b0;
        mem_lat = 1; mem_pend = 1'b0; mem_cnt = 0; mem_addr_q = 32'h0;
        scoreboard_on = 1'b0;
        model_reset();

        // Reset values, then first fetch with a 1-cycle memory.
        tick(); tick();
        check("rst_req", o_req, 1'b0);
        check("rst_stall", o_stall, 1'b1);
        check("rst_if_pc", o_pc, RV);
        reset_n = 1'b1; bus.imem_gnt = 1'b1; bus.if_ready = 1'b1;
        tick();
        check("idle_req", o_req, 1'b0);
        tick();
        check("first_req", o_req, 1'b1);
        check("first_addr", o_addr, 32'h8000_0000);
        bus.imem_rdata = 32'h0000_0013;
        tick();
        tick();
        check("first_valid", o_valid, 1'b1);
        check("first_pc", o_pc, 32'h8000_0000);
        check("first_instr", o_instr, 32'h0000_0013);
        tick();
        check("second_addr", o_addr, 32'h8000_0004);

        // Decode back-pressure while holding.
        bus.if_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", o_valid, 1'b1);
            check("hold_pc", o_pc, 32'h8000_0004);
            check("hold_instr", o_instr, mem_word(32'h8000_0004));
            check("hold_req", o_req, 1'b0);
            check("hold_stall", o_stall, 1'b1);
        end
        bus.if_ready = 1'b1;
        tick();

        // Branch redirect while waiting; the stale response must vanish.
        mem_lat = 3;
        tick();
        bv = 1'b1; bpc = 32'h8000_0103;
        tick();
        check("br_target", o_tgt, 32'h8000_0100);
        bv = 1'b0;
        tick();
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("stale_valid", o_valid, 1'b0);
        mem_lat = 1;
        tick();
        check("br_req", o_req, 1'b1);
        check("br_addr", o_addr, 32'h8000_0100);
        check("br_valid", o_valid, 1'b0);

        // All three sources at once: trap wins.
        tv = 1'b1; tpc = 32'h8000_0004;
        bv = 1'b1; bpc = 32'h8000_0200;
        jv = 1'b1; jpc = 32'h8000_0300;
        tick();
        check("prio_target", o_tgt, 32'h8000_0004);
        check("prio_sel", o_sel, 1'b1);
        check("prio_stall", o_stall, 1'b0);
        tv = 1'b0; bv = 1'b0; jv = 1'b0;

        // Redirect in REQ with a grant offered: no request that cycle.
        jv = 1'b1; jpc = 32'h9000_0000;
        tick();
        check("redir_req_blocked", o_req, 1'b0);
        jv = 1'b0; mem_lat = 3;
        tick();
        check("jmp_req", o_req, 1'b1);
        check("jmp_addr", o_addr, 32'h9000_0000);

        // Reset while waiting; responses during and right after reset are ignored.
        tick();
        reset_n = 1'b0; pc_cur = RV;
        tick();
        tick();
        check("rst_wait_valid", o_valid, 1'b0);
        reset_n = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("post_rst_valid", o_valid, 1'b0);
        check("post_rst_req", o_req, 1'b0);
        tick();
        check("fresh_req", o_req, 1'b1);
        check("fresh_addr", o_addr, 32'h8000_0000);
        check("fresh_valid", o_valid, 1'b0);

        // Randomized traffic.
        scoreboard_on = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bus.imem_gnt = ($urandom_range(0, 9) < 7);
            bus.if_ready = $urandom_range(0, 1) == 1;
            mem_lat      = $urandom_range(1, 3);
            tv  = ($urandom_range(0, 39) == 0);
            bv  = ($urandom_range(0, 19) == 0);
            jv  = ($urandom_range(0, 19) == 0);
            tpc = $urandom; bpc = $urandom; jpc = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                pc_cur  = RV;
            end else begin
                reset_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
